// File: rtl/mux8way16_arbiter.sv
// Round-robin sharing of one 8-way WIDTH-bit select path; grant 1 cycle after req, beats registered 1 cycle after ack.
// Backpressure: a held output beat (out_valid && !out_ready) blocks ack and burst counting; a withdrawn request still releases.
module mux8way16_arbiter #(
  parameter int WIDTH     = 16,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       req,
  input  logic [7:0]       last,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic [WIDTH-1:0] din_c,
  input  logic [WIDTH-1:0] din_d,
  input  logic [WIDTH-1:0] din_e,
  input  logic [WIDTH-1:0] din_f,
  input  logic [WIDTH-1:0] din_g,
  input  logic [WIDTH-1:0] din_h,
  output logic [7:0]       ack,
  output logic [7:0]       gnt,
  output logic [2:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state, state_nxt;
  logic [2:0]             ptr, ptr_nxt, sel_nxt, base, pick, idx;
  logic [7:0]             gnt_nxt, cnt, cnt_nxt;
  logic [7:0][WIDTH-1:0]  din;
  logic                   space, beat, rel, found;

  assign din   = {din_h, din_g, din_f, din_e, din_d, din_c, din_b, din_a};
  assign space = !out_valid || out_ready;
  assign beat  = (state == GRANT) && req[sel] && space;
  assign rel   = (state == GRANT) &&
                 (!req[sel] || (beat && (last[sel] || cnt == 8'(BURST_MAX - 1))));
  assign ack   = beat ? gnt : 8'h00;
  assign busy  = (state == GRANT);

  // On release the search starts just past the releasing requester, so it ends up last.
  assign base = (state == IDLE) ? ptr : sel + 3'd1;

  always_comb begin
    found = 1'b0;
    pick  = base;
    idx   = base;
    for (int k = 0; k < 8; k++) begin
      idx = base + 3'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    gnt_nxt   = gnt;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          sel_nxt   = pick;
          gnt_nxt   = 8'b1 << pick;
          cnt_nxt   = 8'd0;
        end
      end
      GRANT: begin
        if (beat) cnt_nxt = cnt + 8'd1;
        if (rel) begin
          ptr_nxt = sel + 3'd1;
          if (found) begin
            sel_nxt = pick;
            gnt_nxt = 8'b1 << pick;
            cnt_nxt = 8'd0;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 8'h00;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      sel   <= 3'd0;
      gnt   <= 8'h00;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      gnt   <= gnt_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (beat) begin
      out_valid <= 1'b1;
      out_data  <= din[sel];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux8way16_arbiter.sv
// Bench for mux8way16_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_mux8way16_arbiter;
  localparam int WIDTH = 16;
  localparam int BM    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       req = 8'h00;
  logic [7:0]       last = 8'h00;
  logic [WIDTH-1:0] din [8];
  logic             out_ready = 1'b1;
  logic [7:0]       ack, gnt;
  logic [2:0]       sel;
  logic             out_valid, busy;
  logic [WIDTH-1:0] out_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux8way16_arbiter #(.WIDTH(WIDTH), .BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .din_a(din[0]), .din_b(din[1]), .din_c(din[2]), .din_d(din[3]),
    .din_e(din[4]), .din_f(din[5]), .din_g(din[6]), .din_h(din[7]),
    .ack(ack), .gnt(gnt), .sel(sel), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req = 8'h00; last = 8'h00; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) din[i] = '0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  function automatic int pick(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      req = 8'($urandom); last = 8'($urandom); out_ready = 1'($urandom);
      for (int i = 0; i < 8; i++) din[i] = 16'($urandom);
      tick();
      checks++;
      if (gnt !== 8'h00 || ack !== 8'h00 || out_valid !== 1'b0 || out_data !== 16'h0 || sel !== 3'd0 || busy !== 1'b0)
        begin errors++; $display("FAIL reset_hold: gnt=%h ack=%h ov=%b od=%h sel=%0d busy=%b, want all zero", gnt, ack, out_valid, out_data, sel, busy); end
    end
    req = 8'h80; last = 8'h00; out_ready = 1'b0; din[7] = 16'hBEEF;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (sel !== 3'd7 || out_valid !== 1'b1 || out_data !== 16'hBEEF)
      begin errors++; $display("FAIL reset_pre: sel=%0d ov=%b od=%h, want sel=7 ov=1 od=beef", sel, out_valid, out_data); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 8'h00 || ack !== 8'h00 || out_valid !== 1'b0 || out_data !== 16'h0 || sel !== 3'd0 || busy !== 1'b0)
      begin errors++; $display("FAIL reset_async: gnt=%h ack=%h ov=%b od=%h sel=%0d busy=%b, want all zero", gnt, ack, out_valid, out_data, sel, busy); end
  endtask

  task automatic test_single_beat;
    do_reset();
    req = 8'h04; last = 8'h04; din[2] = 16'h1234; out_ready = 1'b1;
    #1;
    checks++;
    if (ack !== 8'h00 || gnt !== 8'h00)
      begin errors++; $display("FAIL single_idle: ack=%h gnt=%h, want 00 00", ack, gnt); end
    tick();
    checks++;
    if (gnt !== 8'h04 || sel !== 3'd2 || ack !== 8'h04 || busy !== 1'b1)
      begin errors++; $display("FAIL single_grant: gnt=%h sel=%0d ack=%h busy=%b, want 04 2 04 1", gnt, sel, ack, busy); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234)
      begin errors++; $display("FAIL single_out: ov=%b od=%h, want 1 1234", out_valid, out_data); end
    req = 8'h00;
    tick();
    checks++;
    if (gnt !== 8'h00 || busy !== 1'b0 || sel !== 3'd2 || out_valid !== 1'b0)
      begin errors++; $display("FAIL single_release: gnt=%h busy=%b sel=%0d ov=%b, want 00 0 2 0", gnt, busy, sel, out_valid); end
  endtask

  task automatic test_round_robin;
    int s;
    do_reset();
    req = 8'hFF; last = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) din[i] = 16'(i);
    for (int k = 1; k <= 9; k++) begin
      tick();
      s = (k - 1) % 8;
      checks++;
      if (sel !== 3'(s) || gnt !== 8'(1 << s) || ack !== 8'(1 << s))
        begin errors++; $display("FAIL rr_grant[%0d]: sel=%0d gnt=%h ack=%h, want sel=%0d", k, sel, gnt, ack, s); end
      if (k >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'((k - 2) % 8))
          begin errors++; $display("FAIL rr_data[%0d]: ov=%b od=%h, want 1 %h", k, out_valid, out_data, 16'((k - 2) % 8)); end
      end
    end
  endtask

  task automatic test_burst_cap;
    int s;
    logic [15:0] d;
    do_reset();
    req = 8'h28; last = 8'h00; out_ready = 1'b1;
    din[3] = 16'h3333; din[5] = 16'h5555;
    for (int k = 1; k <= 12; k++) begin
      tick();
      s = (((k - 1) / 4) % 2 == 0) ? 3 : 5;
      checks++;
      if (sel !== 3'(s) || ack !== 8'(1 << s))
        begin errors++; $display("FAIL burst_grant[%0d]: sel=%0d ack=%h, want sel=%0d", k, sel, ack, s); end
      if (k >= 2) begin
        d = (((k - 2) / 4) % 2 == 0) ? 16'h3333 : 16'h5555;
        checks++;
        if (out_data !== d)
          begin errors++; $display("FAIL burst_data[%0d]: od=%h, want %h", k, out_data, d); end
      end
    end
    do_reset();
    req = 8'h08; last = 8'h00; out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || sel !== 3'd3 || ack !== 8'h08)
        begin errors++; $display("FAIL burst_alone[%0d]: busy=%b sel=%0d ack=%h, want 1 3 08", k, busy, sel, ack); end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    req = 8'h12; last = 8'h00; out_ready = 1'b1;
    din[1] = 16'hA000; din[4] = 16'h4444;
    tick();
    checks++;
    if (sel !== 3'd1 || ack !== 8'h02)
      begin errors++; $display("FAIL bp_grant: sel=%0d ack=%h, want 1 02", sel, ack); end
    tick();
    din[1] = 16'hA001; out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hA000 || ack !== 8'h00)
      begin errors++; $display("FAIL bp_stall: ov=%b od=%h ack=%h, want 1 a000 00", out_valid, out_data, ack); end
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hA000 || ack !== 8'h00 || sel !== 3'd1)
        begin errors++; $display("FAIL bp_hold[%0d]: ov=%b od=%h ack=%h sel=%0d, want 1 a000 00 1", n, out_valid, out_data, ack, sel); end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (ack !== 8'h02)
      begin errors++; $display("FAIL bp_resume_ack: ack=%h, want 02", ack); end
    for (int n = 1; n <= 3; n++) begin
      tick();
      checks++;
      if (out_data !== 16'hA000 + 16'(n) || sel !== ((n == 3) ? 3'd4 : 3'd1))
        begin errors++; $display("FAIL bp_resume[%0d]: od=%h sel=%0d, want %h %0d", n, out_data, sel, 16'hA000 + 16'(n), (n == 3) ? 4 : 1); end
      din[1] = 16'hA000 + 16'(n + 1);
    end
  endtask

  task automatic test_withdraw_wrap;
    do_reset();
    req = 8'hC0; last = 8'hFF; out_ready = 1'b1;
    tick();
    checks++;
    if (sel !== 3'd6)
      begin errors++; $display("FAIL wd_first: sel=%0d, want 6", sel); end
    tick();
    checks++;
    if (sel !== 3'd7 || gnt !== 8'h80)
      begin errors++; $display("FAIL wd_seven: sel=%0d gnt=%h, want 7 80", sel, gnt); end
    req = 8'h41;
    #1;
    checks++;
    if (ack !== 8'h00)
      begin errors++; $display("FAIL wd_noack: ack=%h, want 00", ack); end
    tick();
    checks++;
    if (sel !== 3'd0 || gnt !== 8'h01 || out_valid !== 1'b0)
      begin errors++; $display("FAIL wd_wrap: sel=%0d gnt=%h ov=%b, want 0 01 0", sel, gnt, out_valid); end
  endtask

  // Model: current owner (-1 = none), priority pointer, beats taken this grant, queue of accepted beats.
  task automatic test_random(int ncyc);
    int cur, ptr, beats;
    logic [2:0] msel;
    logic [15:0] q [$];
    logic [7:0] e_ack, e_gnt;
    bit beat, rel;
    do_reset();
    cur = -1; ptr = 0; beats = 0; msel = 3'd0;
    for (int c = 0; c < ncyc; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
      last = 8'($urandom & $urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 8; i++) din[i] = 16'($urandom);
      #1;
      beat  = (cur >= 0) && req[cur] && (q.size() == 0 || out_ready);
      e_ack = beat ? 8'(1 << cur) : 8'h00;
      e_gnt = (cur >= 0) ? 8'(1 << cur) : 8'h00;
      checks++;
      if (ack !== e_ack)
        begin errors++; $display("FAIL rnd_ack[%0d]: ack=%h, want %h", c, ack, e_ack); end
      checks++;
      if (gnt !== e_gnt || sel !== msel || busy !== (cur >= 0))
        begin errors++; $display("FAIL rnd_grant[%0d]: gnt=%h sel=%0d busy=%b, want %h %0d %b", c, gnt, sel, busy, e_gnt, msel, cur >= 0); end
      checks++;
      if (out_valid !== (q.size() != 0) || (q.size() != 0 && out_data !== q[0]))
        begin errors++; $display("FAIL rnd_out[%0d]: ov=%b od=%h, want ov=%b od=%h", c, out_valid, out_data, q.size() != 0, (q.size() != 0) ? q[0] : 16'h0); end
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (beat) begin
        q.push_back(din[cur]);
        beats++;
      end
      if (cur < 0) begin
        if (req != 8'h00) begin
          cur = pick(req, ptr);
          beats = 0;
        end
      end else begin
        rel = !req[cur] || (beat && (last[cur] || beats == BM));
        if (rel) begin
          ptr = (cur + 1) % 8;
          cur = (req != 8'h00) ? pick(req, ptr) : -1;
          beats = 0;
        end
      end
      if (cur >= 0) msel = 3'(cur);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) din[i] = '0;
    test_reset();
    test_single_beat();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_withdraw_wrap();
    test_random(3000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
